// File: rtl/pwm_cap_pkg.sv
// Shared types and constants for the PWM input-capture unit.
package pwm_cap_pkg;

  localparam int unsigned MAX_DW = 32;
  // All-ones at the widest supported width; truncated to DW where used.
  localparam logic [MAX_DW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_cap_filt.sv
// Input conditioning: 2-FF synchronizer, FLT-cycle glitch filter, registered edge detect.
module pwm_cap_filt #(
  parameter int unsigned FLT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cap_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (FLT > 1) ? $clog2(FLT) : 1;

  logic          s1;
  logic          s2;
  logic          lvl_nxt;
  logic [CW-1:0] dcnt;
  logic [CW-1:0] dcnt_nxt;

  // Filter output flips once the synchronized level has disagreed for FLT cycles.
  always_comb begin
    lvl_nxt  = lvl;
    dcnt_nxt = '0;
    if (FLT == 0) begin
      lvl_nxt = s2;
    end else if (s2 != lvl) begin
      if (dcnt == CW'(FLT - 1)) lvl_nxt = s2;
      else                      dcnt_nxt = dcnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      lvl  <= 1'b0;
      dcnt <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= cap_in;
      s2   <= s1;
      lvl  <= lvl_nxt;
      dcnt <= dcnt_nxt;
      rise <= lvl_nxt & ~lvl;
      fall <= ~lvl_nxt & lvl;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of cap_in in clk cycles.
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int unsigned DW  = 16,
  parameter int unsigned FLT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          cap_in,
  output logic [DW-1:0] period,
  output logic [DW-1:0] high_time,
  output logic          valid,
  output logic          ovf,
  output logic          irq,
  output logic          lvl
);

  localparam logic [DW-1:0] CNT_SAT = DW'(CNT_MAX);

  state_t        state;
  logic [DW-1:0] cnt;
  logic [DW-1:0] hi_lat;
  logic [DW-1:0] cnt_inc;
  logic          sat;
  logic          rise;
  logic          fall;

  pwm_cap_filt #(.FLT(FLT)) u_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .cap_in (cap_in),
    .lvl    (lvl),
    .rise   (rise),
    .fall   (fall)
  );

  assign sat     = (cnt == CNT_SAT);
  assign cnt_inc = sat ? cnt : cnt + DW'(1);

  // Measurement FSM; set events are written after clr so they win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_lat    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clr) begin
        ovf <= 1'b0;
        irq <= 1'b0;
      end
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt   <= DW'(1);
              state <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              hi_lat <= cnt;
              cnt    <= cnt_inc;
              state  <= LOW;
            end else if (sat) begin
              ovf   <= 1'b1;
              irq   <= 1'b1;
              cnt   <= '0;
              state <= ARM;
            end else begin
              cnt <= cnt_inc;
            end
          end
          LOW: begin
            if (rise) begin
              period    <= cnt;
              high_time <= hi_lat;
              valid     <= 1'b1;
              irq       <= 1'b1;
              cnt       <= DW'(1);
              state     <= HIGH;
            end else if (sat) begin
              ovf   <= 1'b1;
              irq   <= 1'b1;
              cnt   <= '0;
              state <= ARM;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: vector table plus scoreboard of expected captures.
module tb_pwm_capture;
  import pwm_cap_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr, cap_in;
  logic [15:0] period, high_time;
  logic        valid, ovf, irq, lvl;

  logic        en8, clr8, cap8;
  logic [7:0]  period8, high8;
  logic        valid8, ovf8, irq8, lvl8;

  int tests = 0;
  int fails = 0;
  int valid8_cnt = 0;

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] h;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int h;
    int l;
    int reps;
    int exp_p;
    int exp_h;
  } vec_t;

  int prev_h, prev_l;
  bit have_prev;

  always #5 clk = ~clk;

  pwm_capture #(.DW(16), .FLT(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .cap_in(cap_in),
    .period(period), .high_time(high_time), .valid(valid),
    .ovf(ovf), .irq(irq), .lvl(lvl)
  );

  pwm_capture #(.DW(8), .FLT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .clr(clr8), .cap_in(cap8),
    .period(period8), .high_time(high8), .valid(valid8),
    .ovf(ovf8), .irq(irq8), .lvl(lvl8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every valid strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got period=%0d high_time=%0d expected no capture", period, high_time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("period", 32'(period), 32'(e.p));
        chk("high_time", 32'(high_time), 32'(e.h));
        chk("irq_with_valid", 32'(irq), 32'd1);
      end
    end
    if (valid8) valid8_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic push_prev();
    exp_t e;
    if (have_prev) begin
      e.p = 16'(prev_h + prev_l);
      e.h = 16'(prev_h);
      sb.push_back(e);
    end
  endtask

  task automatic phase(input int h, input int l);
    cap_in = 1'b1;
    push_prev();
    ticks(h);
    cap_in = 1'b0;
    ticks(l);
    prev_h = h;
    prev_l = l;
    have_prev = 1'b1;
  endtask

  task automatic restart();
    ticks(8);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    en = 1'b0;
    ticks(3);
    have_prev = 1'b0;
    en = 1'b1;
    ticks(3);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, 32'(period), 32'd0);
    chk({tag, "_high_time"}, 32'(high_time), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    chk({tag, "_lvl"}, 32'(lvl), 32'd0);
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{h: 3,  l: 5,  reps: 4, exp_p: 8,  exp_h: 3};
    vt[1] = '{h: 2,  l: 2,  reps: 3, exp_p: 4,  exp_h: 2};
    vt[2] = '{h: 7,  l: 3,  reps: 3, exp_p: 10, exp_h: 7};
    vt[3] = '{h: 2,  l: 9,  reps: 3, exp_p: 11, exp_h: 2};
    vt[4] = '{h: 10, l: 20, reps: 2, exp_p: 30, exp_h: 10};

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; cap_in = 1'b0;
    en8 = 1'b0; clr8 = 1'b0; cap8 = 1'b0;
    have_prev = 1'b0; prev_h = 0; prev_l = 0;
    ticks(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    ticks(2);
    chk_all_zero("post_reset");
    en = 1'b1;
    ticks(3);

    // Table of steady patterns; each entry measured from a fresh arm.
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < vt[i].reps; r++) begin
        if (have_prev && (prev_h + prev_l != vt[i].exp_p || prev_h != vt[i].exp_h))
          $display("[TB] vector %0d table entry inconsistent", i);
        phase(vt[i].h, vt[i].l);
      end
      if (i == 0) begin
        ticks(6);
        chk("irq_after_captures", 32'(irq), 32'd1);
      end
      restart();
    end

    // 1-cycle high glitch inside a low phase is ignored.
    phase(3, 5);
    cap_in = 1'b1;
    push_prev();
    ticks(3);
    cap_in = 1'b0;
    ticks(2);
    cap_in = 1'b1;
    tick();
    cap_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("glitch_lvl_low", 32'(lvl), 32'd0);
    end
    prev_h = 3; prev_l = 6; have_prev = 1'b1;
    phase(2, 6);
    phase(3, 5);
    restart();

    // clr alone clears; clr coinciding with a capture loses to the set.
    phase(3, 5);
    phase(3, 5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_irq", 32'(irq), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    prev_l = 6;
    cap_in = 1'b1;
    push_prev();
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (dut.rise) seen = 1'b1;
      end
      if (!seen) begin
        tests++; fails++;
        $display("FAIL clr_capture_wait: got no rise within 10 cycles expected a rise");
      end
    end
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_vs_capture_irq", 32'(irq), 32'd1);
    ticks(3);
    cap_in = 1'b0;
    ticks(4);
    restart();

    // Drop en mid-HIGH: aborted measurement yields nothing, old results hold.
    phase(3, 5);
    phase(3, 5);
    cap_in = 1'b1;
    push_prev();
    ticks(7);
    en = 1'b0;
    ticks(2);
    cap_in = 1'b0;
    ticks(8);
    chk("abort_hold_period", 32'(period), 32'd8);
    chk("abort_hold_high", 32'(high_time), 32'd3);
    chk("abort_no_pending", 32'(sb.size()), 32'd0);
    have_prev = 1'b0;
    en = 1'b1;
    ticks(3);
    phase(4, 4);
    chk("reenable_hold_high", 32'(high_time), 32'd3);
    phase(4, 4);
    phase(4, 4);
    restart();

    // Saturation on the 8-bit instance.
    en8 = 1'b1;
    ticks(3);
    cap8 = 1'b1;
    ticks(259);
    chk("ovf8_before_sat", 32'(ovf8), 32'd0);
    tick();
    chk("ovf8_at_sat", 32'(ovf8), 32'd1);
    chk("irq8_at_sat", 32'(irq8), 32'd1);
    chk("state8_arm", 32'(dut8.state), 32'(ARM));
    chk("valid8_none", 32'(valid8_cnt), 32'd0);
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    chk("ovf8_cleared", 32'(ovf8), 32'd0);
    chk("irq8_cleared", 32'(irq8), 32'd0);
    ticks(300);
    chk("ovf8_stays_clear", 32'(ovf8), 32'd0);
    chk("valid8_still_none", 32'(valid8_cnt), 32'd0);

    // Asynchronous reset during LOW, then re-arm.
    phase(3, 5);
    phase(3, 5);
    cap_in = 1'b1;
    push_prev();
    ticks(3);
    cap_in = 1'b0;
    ticks(6);
    chk("pre_reset_irq", 32'(irq), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    chk("async_reset_pending", 32'(sb.size()), 32'd0);
    have_prev = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(3);
    phase(3, 5);
    phase(3, 5);
    phase(3, 5);
    ticks(8);
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
